// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared opcodes, ALU/writeback codes, FSM states and control bundle for mc_control_unit
package cu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] WB_PC4 = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       opa_sel;
    logic       opb_sel;
    logic [1:0] wb_sel;
    logic       br_un;
    logic       rd_wr;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic [2:0] br_cond;
    logic       illegal;
  } ctl_t;

  // funct7=0 ALU operation for OP / OP-IMM
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic less, input logic equal);
    case (f3)
      3'b000:         return equal;
      3'b001:         return !equal;
      3'b100, 3'b110: return less;
      3'b101, 3'b111: return !less;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// rtl/cu_decoder.sv - combinational RV32I instruction to control-bundle decoder with illegal detection
module cu_decoder
  import cu_pkg::*;
(
  input  logic [31:0] i_instr,
  output ctl_t        o_ctl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;
  ctl_t       ctl;

  assign opcode        = i_instr[6:0];
  assign funct3        = i_instr[14:12];
  assign funct7        = i_instr[31:25];
  assign unused_fields = ^{i_instr[24:15], i_instr[11:7]};

  always_comb begin
    ctl         = '0;
    ctl.br_cond = funct3;
    case (opcode)
      OPC_LUI: begin
        ctl.alu_op = ALU_PASSB; ctl.opb_sel = 1'b1; ctl.wb_sel = WB_ALU; ctl.rd_wr = 1'b1;
      end
      OPC_AUIPC: begin
        ctl.opa_sel = 1'b1; ctl.opb_sel = 1'b1; ctl.wb_sel = WB_ALU; ctl.rd_wr = 1'b1;
      end
      OPC_JAL: begin
        ctl.opa_sel = 1'b1; ctl.opb_sel = 1'b1; ctl.wb_sel = WB_PC4;
        ctl.rd_wr = 1'b1; ctl.is_jump = 1'b1;
      end
      OPC_JALR: begin
        ctl.illegal = (funct3 != 3'b000);
        ctl.opb_sel = 1'b1; ctl.wb_sel = WB_PC4; ctl.rd_wr = 1'b1; ctl.is_jump = 1'b1;
      end
      OPC_BRANCH: begin
        ctl.illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
        ctl.opa_sel   = 1'b1; ctl.opb_sel = 1'b1; ctl.is_branch = 1'b1;
        ctl.br_un     = funct3[2] & funct3[1];
      end
      OPC_LOAD: begin
        ctl.illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        ctl.opb_sel = 1'b1; ctl.wb_sel = WB_MEM; ctl.rd_wr = 1'b1; ctl.is_load = 1'b1;
      end
      OPC_STORE: begin
        ctl.illegal = (funct3 > 3'b010);
        ctl.opb_sel = 1'b1; ctl.is_store = 1'b1;
      end
      OPC_OPIMM: begin
        ctl.alu_op = alu_from_f3(funct3);
        ctl.opb_sel = 1'b1; ctl.wb_sel = WB_ALU; ctl.rd_wr = 1'b1;
        if (funct3 == 3'b001) begin
          ctl.illegal = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          ctl.illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          if (funct7 == 7'b0100000) ctl.alu_op = ALU_SRA;
        end
      end
      OPC_OP: begin
        ctl.wb_sel = WB_ALU; ctl.rd_wr = 1'b1;
        if (funct7 == 7'b0000000) begin
          ctl.alu_op = alu_from_f3(funct3);
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          ctl.alu_op = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          ctl.alu_op = ALU_SRA;
        end else begin
          ctl.illegal = 1'b1;
        end
      end
      OPC_FENCE: ctl.wb_sel = WB_PC4;
      default:   ctl.illegal = 1'b1;
    endcase
    // An illegal instruction must never write state, whether it traps or retires as a NOP
    if (ctl.illegal) begin
      ctl.rd_wr = 1'b0; ctl.is_load = 1'b0; ctl.is_store = 1'b0;
      ctl.is_branch = 1'b0; ctl.is_jump = 1'b0;
    end
  end

  assign o_ctl = ctl;

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle RV32I control FSM; CU_MEM_TIMEOUT_EN adds a memory-ack timeout trap
module mc_control_unit
  import cu_pkg::*;
#(
  parameter int ALU_OP_W     = 4,
  parameter int MEM_TIMEOUT  = 16,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [31:0]         i_instr,
  input  logic                i_br_less,
  input  logic                i_br_equal,
  input  logic                i_mem_ack,
  output logic                o_imem_rden,
  output logic                o_ir_wren,
  output logic                o_mem_rden,
  output logic                o_mem_wren,
  output logic                o_pc_wren,
  output logic                o_pc_sel,
  output logic                o_rd_wren,
  output logic                o_br_un,
  output logic                o_opa_sel,
  output logic                o_opb_sel,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic [1:0]          o_wb_sel,
  output logic                o_insn_vld,
  output logic                o_illegal
);

  state_t state;
  ctl_t   dec_ctl;
  ctl_t   ctl_q;
  logic   taken_q;
  logic   tmo_hit;

  cu_decoder u_decoder (
    .i_instr (i_instr),
    .o_ctl   (dec_ctl)
  );

`ifdef CU_MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tmo_cnt <= '0;
    end else if ((state == FETCH || state == MEM) && !i_mem_ack) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = !i_mem_ack && (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));
`else
  // Without the counter the waits are unbounded; MEM_TIMEOUT has no effect
  assign tmo_hit = (MEM_TIMEOUT < 0);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= FETCH;
      ctl_q   <= '0;
      taken_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (i_mem_ack)    state <= DECODE;
          else if (tmo_hit) state <= TRAP;
        end
        DECODE: begin
          ctl_q <= dec_ctl;
          state <= (dec_ctl.illegal && ILLEGAL_TRAP) ? TRAP : EXEC;
        end
        EXEC: begin
          taken_q <= ctl_q.is_branch & br_taken(ctl_q.br_cond, i_br_less, i_br_equal);
          state   <= (ctl_q.is_load || ctl_q.is_store) ? MEM : WB;
        end
        MEM: begin
          if (i_mem_ack)    state <= WB;
          else if (tmo_hit) state <= TRAP;
        end
        WB:      state <= FETCH;
        default: state <= TRAP;
      endcase
    end
  end

  always_comb begin
    o_imem_rden = 1'b0;
    o_ir_wren   = 1'b0;
    o_mem_rden  = 1'b0;
    o_mem_wren  = 1'b0;
    o_pc_wren   = 1'b0;
    o_pc_sel    = 1'b0;
    o_rd_wren   = 1'b0;
    o_br_un     = 1'b0;
    o_opa_sel   = 1'b0;
    o_opb_sel   = 1'b0;
    o_alu_op    = '0;
    o_wb_sel    = 2'b00;
    o_insn_vld  = 1'b0;
    o_illegal   = 1'b0;
    case (state)
      FETCH: begin
        o_imem_rden = 1'b1;
        // IR must capture the word in the same cycle the fetch completes
        o_ir_wren   = i_mem_ack;
      end
      EXEC, MEM: begin
        o_opa_sel  = ctl_q.opa_sel;
        o_opb_sel  = ctl_q.opb_sel;
        o_alu_op   = ALU_OP_W'(ctl_q.alu_op);
        o_br_un    = ctl_q.br_un;
        o_mem_rden = (state == MEM) && ctl_q.is_load;
        o_mem_wren = (state == MEM) && ctl_q.is_store;
      end
      WB: begin
        o_pc_wren  = 1'b1;
        o_insn_vld = 1'b1;
        o_rd_wren  = ctl_q.rd_wr;
        o_pc_sel   = ctl_q.is_jump | taken_q;
        o_wb_sel   = ctl_q.wb_sel;
        o_illegal  = ctl_q.illegal;
      end
      TRAP:    o_illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - directed and randomized checks of mc_control_unit against an ISA-level model
module tb_mc_control_unit;

  localparam bit ILLEGAL_TRAP = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        br_less, br_equal, mem_ack;
  logic        imem_rden, ir_wren, mem_rden, mem_wren, pc_wren, pc_sel, rd_wren;
  logic        br_un, opa_sel, opb_sel, insn_vld, illegal;
  logic [3:0]  alu_op;
  logic [1:0]  wb_sel;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit illegal, load, store, branch, jump, rd_wr, br_un, opa, opb;
    int alu;
    int wb;
  } exp_t;

  mc_control_unit #(.ALU_OP_W(4), .MEM_TIMEOUT(16), .ILLEGAL_TRAP(ILLEGAL_TRAP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_br_less(br_less),
    .i_br_equal(br_equal), .i_mem_ack(mem_ack), .o_imem_rden(imem_rden),
    .o_ir_wren(ir_wren), .o_mem_rden(mem_rden), .o_mem_wren(mem_wren),
    .o_pc_wren(pc_wren), .o_pc_sel(pc_sel), .o_rd_wren(rd_wren), .o_br_un(br_un),
    .o_opa_sel(opa_sel), .o_opb_sel(opb_sel), .o_alu_op(alu_op), .o_wb_sel(wb_sel),
    .o_insn_vld(insn_vld), .o_illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // ISA-level view: the ALU op is the funct3 row, with the alternate (SUB/SRA) one code higher
  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    int   alu_of_f3 [8];
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    alu_of_f3 = '{0, 2, 3, 4, 5, 6, 8, 9};
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    e = '{default: 0};
    case (op)
      7'h33: begin
        e.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        e.alu = alu_of_f3[f3] + ((f7 == 7'h20) ? 1 : 0);
        e.rd_wr = 1; e.wb = 1;
      end
      7'h13: begin
        e.illegal = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
        e.alu = alu_of_f3[f3] + ((f3 == 3'd5 && f7 == 7'h20) ? 1 : 0);
        e.opb = 1; e.rd_wr = 1; e.wb = 1;
      end
      7'h03: begin
        e.illegal = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        e.load = 1; e.rd_wr = 1; e.opb = 1; e.wb = 2;
      end
      7'h23: begin e.illegal = (f3 > 3'd2); e.store = 1; e.opb = 1; end
      7'h63: begin
        e.illegal = (f3 == 3'd2 || f3 == 3'd3);
        e.branch = 1; e.opa = 1; e.opb = 1; e.br_un = (f3 == 3'd6 || f3 == 3'd7);
      end
      7'h6F: begin e.jump = 1; e.rd_wr = 1; e.opa = 1; e.opb = 1; e.wb = 0; end
      7'h67: begin e.illegal = (f3 != 3'd0); e.jump = 1; e.rd_wr = 1; e.opb = 1; e.wb = 0; end
      7'h37: begin e.alu = 10; e.opb = 1; e.rd_wr = 1; e.wb = 1; end
      7'h17: begin e.opa = 1; e.opb = 1; e.rd_wr = 1; e.wb = 1; end
      7'h0F: ;
      default: e.illegal = 1;
    endcase
    if (e.illegal) begin
      e.load = 0; e.store = 0; e.branch = 0; e.jump = 0; e.rd_wr = 0;
    end
    return e;
  endfunction

  // f3[2] chooses less-than vs equality, f3[0] negates the condition
  function automatic bit ref_taken(input logic [2:0] f3, input bit lt, input bit eq);
    return (f3[2] ? lt : eq) ^ f3[0];
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [6:0]  ops [12];
    logic [31:0] ins;
    int          r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73, 7'h00};
    ops[11] = 7'($urandom);
    ins = $urandom;
    ins[6:0] = ops[$urandom_range(0, 11)];
    r = $urandom_range(0, 3);
    ins[31:25] = (r == 0) ? 7'h00 : (r == 1) ? 7'h20 : 7'($urandom);
    return ins;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; mem_ack = 1'b0;
    adv();
    rst_n = 1'b1;
    #1;
    check("rst_imem_rden", imem_rden, 1);
    check("rst_illegal", illegal, 0);
    check("rst_enables", {pc_wren, insn_vld, rd_wren, mem_rden, mem_wren, ir_wren}, 0);
  endtask

  task automatic run_insn(input logic [31:0] ins, input int fw, input int mw,
                          input bit lt, input bit eq);
    exp_t e;
    e = ref_decode(ins);
    instr = ins;
    for (int w = 0; w <= fw; w++) begin
      mem_ack = (w == fw);
      #1;
      check("fetch_imem_rden", imem_rden, 1);
      check("fetch_ir_wren", ir_wren, mem_ack);
      check("fetch_quiet", {pc_wren, insn_vld, mem_rden, mem_wren}, 0);
      adv();
    end
    mem_ack = 1'b0;
    #1;
    check("decode_quiet", {imem_rden, ir_wren, pc_wren, insn_vld, rd_wren, illegal}, 0);
    adv();
    if (e.illegal && ILLEGAL_TRAP) begin
      for (int k = 0; k < 3; k++) begin
        mem_ack = 1'($urandom);
        #1;
        check("trap_illegal", illegal, 1);
        check("trap_enables", {imem_rden, pc_wren, insn_vld, rd_wren, mem_rden, mem_wren}, 0);
        adv();
      end
      apply_reset();
      return;
    end
    br_less = lt; br_equal = eq;
    #1;
    check("exec_alu_op", alu_op, e.alu);
    check("exec_opa_sel", opa_sel, e.opa);
    check("exec_opb_sel", opb_sel, e.opb);
    check("exec_br_un", br_un, e.br_un);
    check("exec_quiet", {pc_wren, insn_vld, mem_rden, mem_wren, imem_rden}, 0);
    adv();
    // Flip the comparator after EXEC so a late resolution would be caught
    br_less = !lt; br_equal = !eq;
    if (e.load || e.store) begin
      for (int w = 0; w <= mw; w++) begin
        mem_ack = (w == mw);
        #1;
        check("mem_rden", mem_rden, e.load);
        check("mem_wren", mem_wren, e.store);
        check("mem_no_retire", insn_vld, 0);
        adv();
      end
    end
    mem_ack = 1'b0;
    #1;
    check("wb_pc_wren", pc_wren, 1);
    check("wb_insn_vld", insn_vld, 1);
    check("wb_rd_wren", rd_wren, e.rd_wr);
    check("wb_pc_sel", pc_sel, e.jump || (e.branch && ref_taken(ins[14:12], lt, eq)));
    check("wb_illegal", illegal, e.illegal);
    if (e.rd_wr) check("wb_wb_sel", wb_sel, e.wb);
    adv();
  endtask

  initial begin
    rst_n = 1'b0; mem_ack = 1'b0; instr = '0; br_less = 1'b0; br_equal = 1'b0;
    adv(); adv();
    #1;
    check("reset_imem_rden", imem_rden, 1);
    check("reset_outputs", {ir_wren, mem_rden, mem_wren, pc_wren, pc_sel, rd_wren, br_un,
                            opa_sel, opb_sel, alu_op, wb_sel, insn_vld, illegal}, 0);
    rst_n = 1'b1;

    run_insn(32'h002081B3, 0, 0, 1'b0, 1'b0);   // ADD
    run_insn(32'h0000A183, 0, 3, 1'b0, 1'b0);   // LW, dmem ack after 3 waits
    run_insn(32'h00208463, 0, 0, 1'b0, 1'b1);   // BEQ taken
    run_insn(32'h00208463, 1, 0, 1'b1, 1'b0);   // BEQ not taken
    run_insn(32'h0020E463, 0, 0, 1'b1, 1'b0);   // BLTU taken
    run_insn(32'h0000007F, 0, 0, 1'b0, 1'b0);   // illegal opcode, trap then reset

    // SW interrupted by reset while waiting for dmem ack
    instr = 32'h0020A023; mem_ack = 1'b1; #1; adv();
    mem_ack = 1'b0; adv();
    adv();
    #1;
    check("sw_mem_wren", mem_wren, 1);
    rst_n = 1'b0;
    adv();
    #1;
    check("sw_rst_mem_wren", mem_wren, 0);
    check("sw_rst_imem_rden", imem_rden, 1);
    check("sw_rst_insn_vld", insn_vld, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 150; i++) begin
      run_insn(rand_insn(), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom), 1'($urandom));
    end

    mem_ack = 1'b0;
`ifdef CU_MEM_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      #1;
      check("tmo_waiting", imem_rden, 1);
      adv();
    end
    #1;
    check("tmo_trap_illegal", illegal, 1);
    check("tmo_trap_imem", imem_rden, 0);
`else
    for (int k = 0; k < 100; k++) adv();
    #1;
    check("no_tmo_imem_rden", imem_rden, 1);
    check("no_tmo_illegal", illegal, 0);
`endif
    apply_reset();
    run_insn(32'h00000013, 0, 0, 1'b0, 1'b0);   // NOP after recovery

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
